// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - one master port of the shared SPRAM arbiter
interface spram_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  req;
    logic                  we;
    logic [3:0]            wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, we, wmask, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, wmask, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - fixed-priority two-master arbiter with bounded-wait port 1
module spram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spram_arbiter_if.slave        m0,
    spram_arbiter_if.slave        m1,
    output logic                  mem_wren,
    output logic [3:0]            mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       starve;
    logic       m1_win;
    logic       rd_pend0;
    logic       rd_pend1;

    assign starve = (wait_cnt == MAX_W);
    assign m1_win = m1.req & (~m0.req | starve);

    assign m1.gnt = m1_win & ~rst;
    assign m0.gnt = m0.req & ~m1_win & ~rst;

    // Port 0 owns the bus whenever port 1 is not granted, so idle cycles follow port 0.
    always_comb begin
        mem_wren  = 1'b0;
        mem_wmask = m0.wmask;
        mem_addr  = m0.addr;
        mem_wdata = m0.wdata;
        if (m1.gnt) begin
            mem_wren  = m1.we;
            mem_wmask = m1.wmask;
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
        end else if (m0.gnt) begin
            mem_wren  = m0.we;
        end
        if (rst) begin
            mem_wren  = 1'b0;
            mem_wmask = '0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= m0.gnt & ~m0.we;
            rd_pend1 <= m1.gnt & ~m1.we;
            if (m1.gnt || !m1.req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Masking with rst drops a read that was in flight when reset arrived.
    assign m0.rvalid = rd_pend0 & ~rst;
    assign m1.rvalid = rd_pend1 & ~rst;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed and random checks of spram_arbiter
module tb_spram_arbiter;

    localparam int AW = 14;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_wren;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    spram_arbiter_if #(.ADDR_WIDTH(AW)) m0 ();
    spram_arbiter_if #(.ADDR_WIDTH(AW)) m1 ();

    spram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0),
        .m1        (m1),
        .mem_wren  (mem_wren),
        .mem_wmask (mem_wmask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SPRAM macro: byte-masked write, registered read.
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive0(input logic req, input logic we, input logic [3:0] wm,
                          input logic [AW-1:0] a, input logic [31:0] d);
        m0.req = req; m0.we = we; m0.wmask = wm; m0.addr = a; m0.wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [3:0] wm,
                          input logic [AW-1:0] a, input logic [31:0] d);
        m1.req = req; m1.we = we; m1.wmask = wm; m1.addr = a; m1.wdata = d;
    endtask

    task automatic write0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] wm);
        drive0(1'b1, 1'b1, wm, a, d);
        drive1(1'b0, 1'b0, 4'h0, '0, '0);
        next();
    endtask

    logic [31:0]   ref_mem [0:15];
    logic          r0, r1, w0, w1, e0, e1, p0, p1;
    logic [3:0]    wm0, wm1;
    logic [AW-1:0] a0, a1;
    logic [31:0]   d0, d1, xd0, xd1, word;
    logic [3:0]    wcnt;
    int            denied;

    initial begin
        rst = 1'b1;
        drive0(1'b1, 1'b1, 4'hF, 14'h0005, 32'h12345678);
        drive1(1'b1, 1'b1, 4'hF, 14'h0006, 32'h87654321);
        next();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst_m0_gnt", m0.gnt, 0);
            check("rst_m1_gnt", m1.gnt, 0);
            check("rst_wren", mem_wren, 0);
            check("rst_rvalid", {m0.rvalid, m1.rvalid}, 0);
            next();
        end
        rst = 1'b0;
        drive0(1'b0, 1'b0, 4'h0, '0, '0);
        drive1(1'b0, 1'b0, 4'h0, '0, '0);
        mid();
        check("rst_wait_cnt", dut.wait_cnt, 0);
        next();

        // Port 0 full-word write then read-back
        drive0(1'b1, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF);
        mid();
        check("wr_m0_gnt", m0.gnt, 1);
        check("wr_wren", mem_wren, 1);
        check("wr_addr", 32'(mem_addr), 32'h10);
        next();
        drive0(1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        mid();
        check("rd_m0_gnt", m0.gnt, 1);
        check("rd_wren", mem_wren, 0);
        next();
        drive0(1'b0, 1'b0, 4'h0, '0, '0);
        mid();
        check("rd_m0_rvalid", m0.rvalid, 1);
        check("rd_m0_rdata", m0.rdata, 32'hDEADBEEF);
        check("rd_m1_rvalid", m1.rvalid, 0);
        next();

        // Byte masks, including an all-zero mask
        write0(14'h0011, 32'hFFFFFFFF, 4'hF);
        write0(14'h0011, 32'h11223344, 4'h5);
        drive0(1'b1, 1'b1, 4'h0, 14'h0011, 32'h00000000);
        mid();
        check("wm0_gnt", m0.gnt, 1);
        check("wm0_wren", mem_wren, 1);
        check("wm0_mask", mem_wmask, 0);
        next();
        drive0(1'b1, 1'b0, 4'h0, 14'h0011, 32'h0);
        next();
        drive0(1'b0, 1'b0, 4'h0, '0, '0);
        mid();
        check("mask_rvalid", m0.rvalid, 1);
        check("mask_rdata", m0.rdata, 32'hFF22FF44);
        next();

        // Port 1 seeds 0x20 alone, then starves behind continuous port 0 reads
        drive1(1'b1, 1'b1, 4'hF, 14'h0020, 32'hCAFE0020);
        mid();
        check("m1_wr_gnt", m1.gnt, 1);
        check("m1_wr_wren", mem_wren, 1);
        next();
        drive0(1'b1, 1'b0, 4'hF, 14'h0030, 32'h0);
        drive1(1'b1, 1'b0, 4'hF, 14'h0020, 32'h0);
        for (int i = 1; i <= 11; i++) begin
            mid();
            check($sformatf("starve_m1_gnt_c%0d", i), m1.gnt, (i % 5 == 0));
            check($sformatf("starve_m0_gnt_c%0d", i), m0.gnt, (i % 5 != 0));
            check($sformatf("starve_m1_rvalid_c%0d", i), m1.rvalid, (i % 5 == 1) && (i > 1));
            check($sformatf("starve_m0_rvalid_c%0d", i), m0.rvalid, (i > 1) && ((i - 1) % 5 != 0));
            if (m1.rvalid) check("starve_m1_rdata", m1.rdata, 32'hCAFE0020);
            next();
        end

        // Interleaved reads from both ports
        write0(14'h0001, 32'h01010101, 4'hF);
        write0(14'h0002, 32'h02020202, 4'hF);
        drive0(1'b1, 1'b0, 4'hF, 14'h0001, 32'h0);
        mid();
        check("il_m0_gnt", m0.gnt, 1);
        next();
        drive0(1'b0, 1'b0, 4'h0, '0, '0);
        drive1(1'b1, 1'b0, 4'hF, 14'h0002, 32'h0);
        mid();
        check("il_m1_gnt", m1.gnt, 1);
        check("il_m0_rvalid", m0.rvalid, 1);
        check("il_m0_rdata", m0.rdata, 32'h01010101);
        check("il_m1_rvalid_early", m1.rvalid, 0);
        next();
        drive1(1'b0, 1'b0, 4'h0, '0, '0);
        mid();
        check("il_m1_rvalid", m1.rvalid, 1);
        check("il_m1_rdata", m1.rdata, 32'h02020202);
        check("il_m0_rvalid_late", m0.rvalid, 0);
        next();

        // Reset arriving one cycle after a port 1 read grant
        drive1(1'b1, 1'b0, 4'hF, 14'h0002, 32'h0);
        mid();
        check("rmr_m1_gnt", m1.gnt, 1);
        next();
        rst = 1'b1;
        drive1(1'b0, 1'b0, 4'h0, '0, '0);
        mid();
        check("rmr_m1_rvalid_rst", m1.rvalid, 0);
        next();
        rst = 1'b0;
        mid();
        check("rmr_rvalid_after", {m0.rvalid, m1.rvalid}, 0);
        next();

        // Seed the random window so reference and macro agree
        for (int i = 0; i < 16; i++) begin
            word = 32'hA5000000 | 32'(i * 32'h00010101);
            ref_mem[i] = word;
            write0(14'h0040 + 14'(i), word, 4'hF);
        end
        drive0(1'b0, 1'b0, 4'h0, '0, '0);
        next();

        wcnt = '0; p0 = 1'b0; p1 = 1'b0; xd0 = '0; xd1 = '0; denied = 0;
        for (int c = 0; c < 10000; c++) begin
            r0 = ($urandom_range(0, 9) < 7);
            r1 = ($urandom_range(0, 1) == 1);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            wm0 = 4'($urandom_range(0, 15));
            wm1 = 4'($urandom_range(0, 15));
            a0 = 14'h0040 + 14'($urandom_range(0, 15));
            a1 = 14'h0040 + 14'($urandom_range(0, 15));
            d0 = $urandom;
            d1 = $urandom;
            drive0(r0, w0, wm0, a0, d0);
            drive1(r1, w1, wm1, a1, d1);
            e1 = r1 & (~r0 | (wcnt == 4'(MW)));
            e0 = r0 & ~e1;
            mid();
            check("rnd_one_grant", m0.gnt & m1.gnt, 0);
            check("rnd_m0_gnt", m0.gnt, e0);
            check("rnd_m1_gnt", m1.gnt, e1);
            check("rnd_wren", mem_wren, (e0 & w0) | (e1 & w1));
            check("rnd_m0_rvalid", m0.rvalid, p0);
            check("rnd_m1_rvalid", m1.rvalid, p1);
            if (p0) check("rnd_m0_rdata", m0.rdata, xd0);
            if (p1) check("rnd_m1_rdata", m1.rdata, xd1);
            if (r1 && !m1.gnt) denied++;
            else denied = 0;
            check("rnd_max_wait", (denied <= MW), 1);
            p0 = e0 & ~w0;
            p1 = e1 & ~w1;
            if (e0) xd0 = ref_mem[a0[3:0]];
            if (e1) xd1 = ref_mem[a1[3:0]];
            for (int b = 0; b < 4; b++) begin
                if (e0 && w0 && wm0[b]) ref_mem[a0[3:0]][8*b +: 8] = d0[8*b +: 8];
                if (e1 && w1 && wm1[b]) ref_mem[a1[3:0]][8*b +: 8] = d1[8*b +: 8];
            end
            if (e1 || !r1) wcnt = '0;
            else if (wcnt != 4'(MW)) wcnt = wcnt + 4'd1;
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
